store_narrow_buf: RTL

- Store-side counterpart of the immediate/load extender: narrows 32-bit register data to word, halfword or byte stores.
- Generates little-endian byte enables and lane-replicated write data.
- Buffers accepted stores in a small FIFO and drains them to data memory over a valid/ready handshake.
- Sits between the MEM stage and the DM port; flags misaligned stores instead of issuing them.

---
 rtl/store_pkg.sv | 23 ++
 rtl/store_lane_align.sv | 45 ++++
 rtl/store_narrow_buf.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/store_pkg.sv
// Shared types for the store narrowing buffer: store-width encodings,
// byte-enable width and the buffered entry layout.
package store_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef enum logic [1:0] {
        OP_SW  = 2'b00,
        OP_SH  = 2'b01,
        OP_SB  = 2'b10,
        OP_RSV = 2'b11
    } store_op_e;

    // One buffered store: word address, lane-aligned data, byte enables.
    typedef struct packed {
        logic [ADDR_W-1:2] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } store_entry_t;

endpackage

// File: rtl/store_lane_align.sv
// Combinational lane alignment for a store request.
// Ports:
//   req_op     - store width (word/half/byte/reserved)
//   req_addr   - low two address bits
//   req_data   - register data
//   wdata      - lane-replicated write data
//   be         - little-endian byte enables
//   misaligned - request cannot be issued
module store_lane_align
    import store_pkg::*;
(
    input  logic [1:0]        req_op,
    input  logic [1:0]        req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic [DATA_W-1:0] wdata,
    output logic [BE_W-1:0]   be,
    output logic              misaligned
);

    // Replicate the narrow datum across every lane so the enables pick the lane.
    always_comb begin
        wdata      = req_data;
        be         = '0;
        misaligned = 1'b0;
        case (store_op_e'(req_op))
            OP_SW: begin
                be         = 4'b1111;
                misaligned = (req_addr != 2'b00);
            end
            OP_SH: begin
                wdata      = {2{req_data[15:0]}};
                be         = req_addr[1] ? 4'b1100 : 4'b0011;
                misaligned = req_addr[0];
            end
            OP_SB: begin
                wdata = {4{req_data[7:0]}};
                be    = 4'b0001 << req_addr;
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/store_narrow_buf.sv
// Store narrowing buffer between the MEM stage and the data-memory port.
// Narrows register data to word/half/byte stores, queues accepted stores in a
// small FIFO and drains them in order over a valid/ready handshake. Misaligned
// requests are consumed, reported on misalign/err_addr and never issued.
// Optional macro STORE_MERGE_EN: aligned stores hitting the tail entry's word
// merge into it instead of allocating a new entry.
// Ports:
//   clk, reset              - clock, synchronous active-high reset
//   req_valid/ready         - request handshake
//   req_addr/data/op        - store address, register data, store width
//   mem_valid/ready         - drain handshake
//   mem_addr/wdata/be       - head entry (word address, data, byte enables)
//   misalign, err_addr      - rejection pulse and last rejected address
//   count                   - FIFO occupancy
module store_narrow_buf
    import store_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic [1:0]        req_op,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [BE_W-1:0]   mem_be,
    output logic              misalign,
    output logic [ADDR_W-1:0] err_addr,
    output logic [CNT_W-1:0]  count
);

    localparam int unsigned     PTR_W   = CNT_W - 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    store_entry_t      fifo_q [DEPTH];
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [CNT_W-1:0]  count_q;
    logic              misalign_q;
    logic [ADDR_W-1:0] err_addr_q;

    logic [DATA_W-1:0] al_wdata;
    logic [BE_W-1:0]   al_be;
    logic              al_mis;

    logic              empty;
    logic              full;
    logic              pop;
    logic              merge_ok;
    logic              accept;
    logic              push;
    logic              do_merge;
    logic              reject;
    logic [PTR_W-1:0]  rd_ptr;

    store_lane_align u_align (
        .req_op     (req_op),
        .req_addr   (req_addr[1:0]),
        .req_data   (req_data),
        .wdata      (al_wdata),
        .be         (al_be),
        .misaligned (al_mis)
    );

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);
    assign pop   = !empty && mem_ready;

`ifdef STORE_MERGE_EN
    logic [PTR_W-1:0] tail_last;
    store_entry_t     merged;

    assign tail_last = tail_q - PTR_W'(1);

    // The tail may only absorb a store if it is not leaving on this edge.
    assign merge_ok = !al_mis && !empty
                   && (fifo_q[tail_last].addr == req_addr[ADDR_W-1:2])
                   && !((count_q == CNT_W'(1)) && pop);

    // Enabled lanes of the request overwrite the tail; enables accumulate.
    always_comb begin
        merged = fifo_q[tail_last];
        for (int unsigned i = 0; i < BE_W; i++) begin
            if (al_be[i]) begin
                merged.wdata[8*i +: 8] = al_wdata[8*i +: 8];
            end
        end
        merged.be = fifo_q[tail_last].be | al_be;
    end
`else
    assign merge_ok = 1'b0;
`endif

    assign req_ready = !full || merge_ok;
    assign accept    = req_valid && req_ready;
    assign reject    = accept && al_mis;
    assign do_merge  = accept && merge_ok;
    assign push      = accept && !al_mis && !merge_ok;

    // When empty, show the slot just drained so mem_* hold the last head.
    assign rd_ptr = empty ? (head_q - PTR_W'(1)) : head_q;

    assign mem_valid = !empty;
    assign mem_addr  = {fifo_q[rd_ptr].addr, 2'b00};
    assign mem_wdata = fifo_q[rd_ptr].wdata;
    assign mem_be    = fifo_q[rd_ptr].be;
    assign misalign  = misalign_q;
    assign err_addr  = err_addr_q;
    assign count     = count_q;

    // FIFO storage, pointers, occupancy and error latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
            err_addr_q <= '0;
        end else begin
            if (push) begin
                fifo_q[tail_q] <= '{addr:  req_addr[ADDR_W-1:2],
                                    wdata: al_wdata,
                                    be:    al_be};
                tail_q <= tail_q + PTR_W'(1);
            end
`ifdef STORE_MERGE_EN
            if (do_merge) begin
                fifo_q[tail_last] <= merged;
            end
`endif
            if (pop) begin
                head_q <= head_q + PTR_W'(1);
            end
            count_q    <= count_q + CNT_W'(push) - CNT_W'(pop);
            misalign_q <= reject;
            if (reject) begin
                err_addr_q <= req_addr;
            end
        end
    end

`ifndef STORE_MERGE_EN
    logic unused_merge;
    assign unused_merge = do_merge;
`endif

endmodule
